// File: rtl/coprocessor0_register_file.sv
// ---------------------------------------------------------------------------
// coprocessor0_register_file
//
// CP0 register file sitting beside the writeback stage. It accepts mtc0
// writes, serves mfc0 reads, commits exceptions and eret, runs the
// Count/Compare timer and produces the interrupt request for the pipeline.
//
// Implemented registers (reg,sel): BadVAddr (8,0), Count (9,0),
// Compare (11,0), Status (12,0), Cause (13,0), EPC (14,0).
// Every other address reads 0 and ignores writes.
//
// Optional feature macro: CP0_TIMER_EN
//   defined   : Count, Compare, timer flag and tick divider are built.
//   undefined : Count/Compare read 0, timer flag is constant 0, no timer flops.
//
// Parameters:
//   RESET_BEV     reset value of Status.bev
//   COUNT_DIVIDE  clock cycles per Count increment (1 or 2)
//
// Ports:
//   clock                      core clock, rising edge
//   reset                      synchronous active-high reset
//   wb_to_cp0                  address, select, write enable, write data
//   read_data                  combinational read of the addressed register
//   exception_valid            commit an exception this cycle
//   exception_code             ExcCode recorded in Cause
//   exception_pc               PC of the faulting instruction
//   exception_delay_slot       faulting instruction sits in a delay slot
//   exception_bad_vaddr_valid  exception carries a bad virtual address
//   exception_bad_vaddr        faulting address
//   eret                       commit eret this cycle
//   hardware_interrupt         external interrupt lines, level-sensitive
//   status                     current Status
//   epc                        current EPC (eret target)
//   interrupt_request          pending enabled interrupt
// ---------------------------------------------------------------------------
package coprocessor0_pkg;
  typedef struct packed {
    logic [4:0]  address_register;
    logic [2:0]  address_select;
    logic        write_enabled;
    logic [31:0] write_data;
  } WBToCP0Data;
endpackage

module coprocessor0_register_file
  import coprocessor0_pkg::*;
#(
  parameter bit RESET_BEV    = 1'b1,
  parameter int COUNT_DIVIDE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  WBToCP0Data  wb_to_cp0,
  output logic [31:0] read_data,
  input  logic        exception_valid,
  input  logic [4:0]  exception_code,
  input  logic [31:0] exception_pc,
  input  logic        exception_delay_slot,
  input  logic        exception_bad_vaddr_valid,
  input  logic [31:0] exception_bad_vaddr,
  input  logic        eret,
  input  logic [5:0]  hardware_interrupt,
  output logic [31:0] status,
  output logic [31:0] epc,
  output logic        interrupt_request
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  generate
    if (COUNT_DIVIDE != 1 && COUNT_DIVIDE != 2) begin : g_bad_divide
      $error("COUNT_DIVIDE must be 1 or 2");
    end
  endgenerate

  // Status fields
  logic [7:0]  status_mask_reg;
  logic        status_exl_reg;
  logic        status_ie_reg;

  // Cause fields
  logic        cause_bd_reg;
  logic [5:0]  cause_hw_reg;
  logic [1:0]  cause_sw_reg;
  logic [4:0]  cause_code_reg;

  logic [31:0] epc_reg;
  logic [31:0] bad_vaddr_reg;

  logic        timer_flag;
  logic [31:0] count_value;
  logic [31:0] compare_value;

  // Only select 0 exists for the implemented registers.
  logic addr_sel0;
  logic wr_sel0;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;

  assign addr_sel0 = (wb_to_cp0.address_select == 3'd0);
  assign wr_sel0   = wb_to_cp0.write_enabled && addr_sel0;
  assign wr_status = wr_sel0 && (wb_to_cp0.address_register == REG_STATUS);
  assign wr_cause  = wr_sel0 && (wb_to_cp0.address_register == REG_CAUSE);
  assign wr_epc    = wr_sel0 && (wb_to_cp0.address_register == REG_EPC);

  always_ff @(posedge clock) begin
    if (reset) begin
      status_mask_reg <= '0;
      status_exl_reg  <= 1'b0;
      status_ie_reg   <= 1'b0;
      cause_bd_reg    <= 1'b0;
      cause_hw_reg    <= '0;
      cause_sw_reg    <= '0;
      cause_code_reg  <= '0;
      epc_reg         <= '0;
      bad_vaddr_reg   <= '0;
    end else begin
      cause_hw_reg <= hardware_interrupt;

      if (wr_status) begin
        status_mask_reg <= wb_to_cp0.write_data[15:8];
        status_ie_reg   <= wb_to_cp0.write_data[0];
      end

      // EXL is the only Status field contended by exception/eret.
      if (exception_valid)
        status_exl_reg <= 1'b1;
      else if (eret)
        status_exl_reg <= 1'b0;
      else if (wr_status)
        status_exl_reg <= wb_to_cp0.write_data[1];

      if (wr_cause)
        cause_sw_reg <= wb_to_cp0.write_data[9:8];

      if (exception_valid)
        cause_code_reg <= exception_code;

      // A nested exception (EXL already set) keeps the original EPC/BD,
      // so the mtc0 write is free to land on EPC in that case.
      if (exception_valid && !status_exl_reg) begin
        epc_reg      <= exception_delay_slot ? (exception_pc - 32'd4) : exception_pc;
        cause_bd_reg <= exception_delay_slot;
      end else if (wr_epc) begin
        epc_reg <= wb_to_cp0.write_data;
      end

      if (exception_valid && exception_bad_vaddr_valid)
        bad_vaddr_reg <= exception_bad_vaddr;
    end
  end

`ifdef CP0_TIMER_EN
  logic        tick_reg;
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        timer_flag_reg;
  logic        count_step;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = wr_sel0 && (wb_to_cp0.address_register == REG_COUNT);
  assign wr_compare = wr_sel0 && (wb_to_cp0.address_register == REG_COMPARE);
  assign count_step = (COUNT_DIVIDE == 1) ? 1'b1 : tick_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_reg       <= 1'b0;
      count_reg      <= '0;
      compare_reg    <= '0;
      timer_flag_reg <= 1'b0;
    end else begin
      tick_reg <= ~tick_reg;

      if (wr_count)
        count_reg <= wb_to_cp0.write_data;
      else if (count_step)
        count_reg <= count_reg + 32'd1;

      if (wr_compare)
        compare_reg <= wb_to_cp0.write_data;

      // Clearing by a Compare write beats a match in the same cycle.
      if (wr_compare)
        timer_flag_reg <= 1'b0;
      else if (count_reg == compare_reg)
        timer_flag_reg <= 1'b1;
    end
  end

  assign timer_flag    = timer_flag_reg;
  assign count_value   = count_reg;
  assign compare_value = compare_reg;
`else
  assign timer_flag    = 1'b0;
  assign count_value   = '0;
  assign compare_value = '0;
`endif

  logic [31:0] status_value;
  logic [31:0] cause_value;
  logic        cause_ip7;

  assign cause_ip7 = cause_hw_reg[5] | timer_flag;

  assign status_value = {9'b0, RESET_BEV, 6'b0, status_mask_reg, 6'b0,
                         status_exl_reg, status_ie_reg};

  assign cause_value = {cause_bd_reg, timer_flag, 14'b0, cause_ip7,
                        cause_hw_reg[4:0], cause_sw_reg, 1'b0,
                        cause_code_reg, 2'b0};

  always_comb begin
    read_data = '0;
    if (addr_sel0) begin
      case (wb_to_cp0.address_register)
        REG_BADVADDR: read_data = bad_vaddr_reg;
        REG_COUNT:    read_data = count_value;
        REG_COMPARE:  read_data = compare_value;
        REG_STATUS:   read_data = status_value;
        REG_CAUSE:    read_data = cause_value;
        REG_EPC:      read_data = epc_reg;
        default:      read_data = '0;
      endcase
    end
  end

  assign status = status_value;
  assign epc    = epc_reg;
  assign interrupt_request = status_ie_reg & ~status_exl_reg &
                             (|(cause_value[15:8] & status_mask_reg));

endmodule

// File: tb/tb_coprocessor0_register_file.sv
// Directed-vector bench for coprocessor0_register_file.
module tb_coprocessor0_register_file;
  import coprocessor0_pkg::*;

  logic        clock;
  logic        reset;
  WBToCP0Data  wb_to_cp0;
  logic [31:0] read_data;
  logic        exception_valid;
  logic [4:0]  exception_code;
  logic [31:0] exception_pc;
  logic        exception_delay_slot;
  logic        exception_bad_vaddr_valid;
  logic [31:0] exception_bad_vaddr;
  logic        eret;
  logic [5:0]  hardware_interrupt;
  logic [31:0] status;
  logic [31:0] epc;
  logic        interrupt_request;

  int vec_count;
  int miscompare_count;

  coprocessor0_register_file #(.RESET_BEV(1'b1), .COUNT_DIVIDE(2)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .wb_to_cp0                 (wb_to_cp0),
    .read_data                 (read_data),
    .exception_valid           (exception_valid),
    .exception_code            (exception_code),
    .exception_pc              (exception_pc),
    .exception_delay_slot      (exception_delay_slot),
    .exception_bad_vaddr_valid (exception_bad_vaddr_valid),
    .exception_bad_vaddr       (exception_bad_vaddr),
    .eret                      (eret),
    .hardware_interrupt        (hardware_interrupt),
    .status                    (status),
    .epc                       (epc),
    .interrupt_request         (interrupt_request)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompare_count++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
    wb_to_cp0.address_register = r;
    wb_to_cp0.address_select   = s;
    wb_to_cp0.write_data       = d;
    wb_to_cp0.write_enabled    = 1'b1;
    step();
    wb_to_cp0.write_enabled    = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] r, input logic [2:0] s,
                          input logic [31:0] exp);
    wb_to_cp0.address_register = r;
    wb_to_cp0.address_select   = s;
    wb_to_cp0.write_enabled    = 1'b0;
    #1;
    check_vec(tag, read_data, exp);
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                     input logic bvv, input logic [31:0] bv);
    exception_valid           = 1'b1;
    exception_code            = code;
    exception_pc              = pc;
    exception_delay_slot      = ds;
    exception_bad_vaddr_valid = bvv;
    exception_bad_vaddr       = bv;
    step();
    exception_valid           = 1'b0;
    exception_bad_vaddr_valid = 1'b0;
  endtask

  initial begin
    vec_count                 = 0;
    miscompare_count          = 0;
    reset                     = 1'b1;
    wb_to_cp0                 = '0;
    exception_valid           = 1'b0;
    exception_code            = '0;
    exception_pc              = '0;
    exception_delay_slot      = 1'b0;
    exception_bad_vaddr_valid = 1'b0;
    exception_bad_vaddr       = '0;
    eret                      = 1'b0;
    hardware_interrupt        = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check_vec("rst_status_port", status, 32'h0040_0000);
    check_vec("rst_epc_port", epc, 32'h0);
    check_vec("rst_irq", {31'b0, interrupt_request}, 32'h0);
    rd_check("rst_status", 5'd12, 3'd0, 32'h0040_0000);
    rd_check("rst_cause", 5'd13, 3'd0, 32'h0);
    rd_check("rst_epc", 5'd14, 3'd0, 32'h0);
    rd_check("rst_badvaddr", 5'd8, 3'd0, 32'h0);
    rd_check("rst_count", 5'd9, 3'd0, 32'h0);
    rd_check("rst_compare", 5'd11, 3'd0, 32'h0);

    // Unimplemented select ignores writes and reads zero
    mtc0(5'd12, 3'd1, 32'hFFFF_FFFF);
    rd_check("sel1_status_read", 5'd12, 3'd1, 32'h0);
    rd_check("sel1_no_effect", 5'd12, 3'd0, 32'h0040_0000);

    // Writable-field masks
    mtc0(5'd12, 3'd0, 32'hFFFF_FFFF);
    rd_check("status_mask_write", 5'd12, 3'd0, 32'h0040_FF03);
    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    rd_check("cause_mask_write", 5'd13, 3'd0, 32'h0000_0300);
    mtc0(5'd8, 3'd0, 32'hDEAD_BEEF);
    rd_check("badvaddr_ro", 5'd8, 3'd0, 32'h0);
    mtc0(5'd13, 3'd0, 32'h0);
    mtc0(5'd12, 3'd0, 32'h0);

    // Exception in delay slot with bad address
    exc(5'd4, 32'hBFC0_0104, 1'b1, 1'b1, 32'h0000_0003);
    rd_check("exc1_epc", 5'd14, 3'd0, 32'hBFC0_0100);
    rd_check("exc1_cause", 5'd13, 3'd0, 32'h8000_0010);
    rd_check("exc1_badvaddr", 5'd8, 3'd0, 32'h0000_0003);
    rd_check("exc1_status", 5'd12, 3'd0, 32'h0040_0002);

    // Nested exception: EPC/BD held, code updated
    exc(5'd5, 32'h8000_0000, 1'b0, 1'b0, 32'h0);
    rd_check("exc2_epc", 5'd14, 3'd0, 32'hBFC0_0100);
    rd_check("exc2_cause", 5'd13, 3'd0, 32'h8000_0014);
    rd_check("exc2_badvaddr", 5'd8, 3'd0, 32'h0000_0003);

    eret = 1'b1;
    step();
    eret = 1'b0;
    rd_check("eret_status", 5'd12, 3'd0, 32'h0040_0000);

    // Exception beats an mtc0 EPC in the same cycle
    wb_to_cp0.address_register = 5'd14;
    wb_to_cp0.address_select   = 3'd0;
    wb_to_cp0.write_data       = 32'h0000_1234;
    wb_to_cp0.write_enabled    = 1'b1;
    exc(5'd8, 32'h0040_0010, 1'b0, 1'b0, 32'h0);
    wb_to_cp0.write_enabled    = 1'b0;
    rd_check("exc_vs_mtc0_epc", 5'd14, 3'd0, 32'h0040_0010);
    rd_check("exc3_cause", 5'd13, 3'd0, 32'h0000_0020);
    rd_check("exc3_status", 5'd12, 3'd0, 32'h0040_0002);

    // eret beats mtc0 on EXL, IE still taken from the write
    eret = 1'b1;
    wb_to_cp0.address_register = 5'd12;
    wb_to_cp0.write_data       = 32'h0000_0003;
    wb_to_cp0.write_enabled    = 1'b1;
    step();
    eret = 1'b0;
    wb_to_cp0.write_enabled    = 1'b0;
    rd_check("eret_vs_mtc0_status", 5'd12, 3'd0, 32'h0040_0001);

    mtc0(5'd14, 3'd0, 32'h0000_1234);
    check_vec("epc_port_mtc0", epc, 32'h0000_1234);

    // Hardware interrupt with registered sampling
    mtc0(5'd12, 3'd0, 32'h0000_0401);
    hardware_interrupt = 6'b000001;
    #1;
    check_vec("hw_irq_same_cycle", {31'b0, interrupt_request}, 32'h0);
    step();
    check_vec("hw_irq_next_cycle", {31'b0, interrupt_request}, 32'h1);
    rd_check("hw_cause", 5'd13, 3'd0, 32'h0000_0420);
    mtc0(5'd12, 3'd0, 32'h0000_0001);
    check_vec("hw_irq_masked", {31'b0, interrupt_request}, 32'h0);
    hardware_interrupt = 6'b000000;
    step();

`ifdef CP0_TIMER_EN
    // Any four edges contain exactly two ticks, so the wrap is phase-independent.
    mtc0(5'd9, 3'd0, 32'hFFFF_FFFE);
    mtc0(5'd11, 3'd0, 32'h0000_0000);
    step();
    step();
    step();
    rd_check("timer_count_wrap", 5'd9, 3'd0, 32'h0);
    step();
    rd_check("timer_flag_cause", 5'd13, 3'd0, 32'h4000_8020);
    mtc0(5'd12, 3'd0, 32'h0000_8001);
    check_vec("timer_irq", {31'b0, interrupt_request}, 32'h1);
    mtc0(5'd11, 3'd0, 32'hFFFF_FF00);
    rd_check("timer_flag_clear", 5'd13, 3'd0, 32'h0000_0020);
    check_vec("timer_irq_clear", {31'b0, interrupt_request}, 32'h0);
`else
    mtc0(5'd9, 3'd0, 32'h1234_5678);
    rd_check("no_timer_count", 5'd9, 3'd0, 32'h0);
    mtc0(5'd11, 3'd0, 32'h0000_0000);
    rd_check("no_timer_compare", 5'd11, 3'd0, 32'h0);
    step();
    step();
    rd_check("no_timer_cause", 5'd13, 3'd0, 32'h0000_0020);
    mtc0(5'd12, 3'd0, 32'h0000_8001);
    check_vec("no_timer_irq", {31'b0, interrupt_request}, 32'h0);
`endif

    // Reset mid-operation drops a pending exception
    mtc0(5'd13, 3'd0, 32'h0000_0300);
    reset = 1'b1;
    exc(5'd12, 32'h8000_1000, 1'b0, 1'b1, 32'h0000_0055);
    reset = 1'b0;
    check_vec("midrst_status", status, 32'h0040_0000);
    check_vec("midrst_epc", epc, 32'h0);
    check_vec("midrst_irq", {31'b0, interrupt_request}, 32'h0);
    rd_check("midrst_cause", 5'd13, 3'd0, 32'h0);
    rd_check("midrst_badvaddr", 5'd8, 3'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule

// File: doc/coprocessor0_register_file.md
Name: coprocessor0_register_file

Overview:
- CP0 register file: the responder for the writeback-to-CP0 write channel (WBToCP0Data) and the owner of the StatusData, CauseData and EPCData state.
- Sits beside the writeback stage. Accepts mtc0 writes, serves mfc0 reads, commits exceptions and eret, runs the Count/Compare timer, and produces the interrupt request returned to the pipeline.

Parameters:
- RESET_BEV, 1, reset value of Status.bev.
- COUNT_DIVIDE, 2, clock cycles per Count increment; legal values 1 or 2.

Ports:
- clock  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_to_cp0  in  WBToCP0Data  register/select address, write_enabled, write_data (32).
- read_data  out  32  combinational read of the register addressed by wb_to_cp0.address_register/address_select.
- exception_valid  in  1  commit an exception this cycle.
- exception_code  in  5  ExcCode to record in Cause.
- exception_pc  in  32  PC of the faulting instruction.
- exception_delay_slot  in  1  faulting instruction is in a delay slot.
- exception_bad_vaddr_valid  in  1  exception carries a bad virtual address (AdEL/AdES).
- exception_bad_vaddr  in  32  the faulting address.
- eret  in  1  commit eret this cycle.
- hardware_interrupt  in  6  external interrupt lines, level-sensitive.
- status  out  32  current Status (StatusData layout).
- epc  out  32  current EPC, used as the eret target.
- interrupt_request  out  1  pending enabled interrupt.

Behaviour:
- Implemented registers (reg,sel): BadVAddr (8,0), Count (9,0), Compare (11,0), Status (12,0), Cause (13,0), EPC (14,0). All other addresses read 0 and ignore writes.
- Reset values:
  - Status: bev = RESET_BEV, all other bits 0.
  - Cause, EPC, BadVAddr, Count, Compare, timer flag, tick divider: all 0.
  - Outputs at reset: status = 0x00400000 when RESET_BEV=1; epc = 0; interrupt_request = 0.
- Writable fields:
  - Status: mask[15:8], exception_level[1], interrupt_enabled[0]. bev and zero fields are read-only.
  - Cause: software_interrupt[9:8] only.
  - EPC, Count, Compare: all 32 bits.
  - BadVAddr: read-only.
- Writes take effect on the next edge. A read in the same cycle returns the old value.
- Exception commit (exception_valid=1):
  - Status.exception_level <= 1.
  - Cause.exception_code <= exception_code.
  - If Status.exception_level was 0 before the edge: EPC <= exception_delay_slot ? exception_pc-4 : exception_pc, and Cause.delay_slot <= exception_delay_slot. If it was 1, EPC and delay_slot hold their values.
  - If exception_bad_vaddr_valid: BadVAddr <= exception_bad_vaddr.
- eret: Status.exception_level <= 0.
- Same-cycle priority: exception_valid > eret > mtc0 write, applied per field. Fields not touched by the winning event still accept the mtc0 write.
- Hardware interrupts: Cause[15:10] <= hardware_interrupt every cycle (one-cycle registered sample).
- Timer:
  - Tick divider toggles every cycle. Count increments by 1 (mod 2^32, wraps 0xFFFFFFFF -> 0) on cycles where the tick is 1 (COUNT_DIVIDE=2) or on every cycle (COUNT_DIVIDE=1).
  - A Count write overrides the increment in that cycle.
  - Timer flag sets on the edge after Count == Compare. It stays set until a Compare write, which clears it; a clear in the same cycle as a match wins.
  - Cause.yimer_interrupt (bit 30) = timer flag. Cause.IP7 (bit 15) reads hardware_interrupt[5] | timer flag.
- interrupt_request = Status.interrupt_enabled & ~Status.exception_level & |(Cause[15:8] & Status.mask). Combinational from registered state only.
- Reset asserted mid-operation restores all reset values on that edge; pending events are dropped.

Optional Feature:
- CP0_TIMER_EN.
- Defined: Count, Compare, timer flag and tick divider are implemented as described above.
- Undefined:
  - Count and Compare read 0 and ignore writes.
  - Timer flag and Cause bit 30 are constant 0.
  - Cause.IP7 = hardware_interrupt[5] only.
  - No timer flops are synthesized.

Test Plan:
- Reset, then read every implemented address -> Status=0x00400000; Cause, EPC, BadVAddr, Count and Compare all 0; interrupt_request=0.
- mtc0 Status=0xFFFFFFFF -> read Status=0x0040FF03; mtc0 Cause=0xFFFFFFFF -> read Cause=0x00000300.
- Exception code 4, pc=0xBFC00104, delay_slot=1, bad_vaddr=0x00000003 -> EPC=0xBFC00100, Cause=0x80000010, BadVAddr=0x00000003, EXL=1. A second exception at pc 0x80000000 -> EPC unchanged, code updated. eret -> EXL=0.
- Same-cycle exception + mtc0 EPC=0x1234 with EXL=0 -> EPC=exception-derived value. Same-cycle eret + mtc0 Status=0x00000003 -> IE=1, EXL=0.
- Count=0xFFFFFFFE, Compare=0x00000000, COUNT_DIVIDE=2 -> Count wraps to 0 after 4 cycles, timer flag set one cycle later. Status=0x00008001 -> interrupt_request=1. Compare write -> flag and request clear next cycle.
- hardware_interrupt=6'b000001, Status=0x00000401 -> interrupt_request rises exactly one cycle after the input. With Status.mask=0, request stays 0.
